lvds_n_x_7bit_word_aligner: RTL and testbench
=============================================

Name: lvds_n_x_7bit_word_aligner

Overview:
- Per-channel 7-bit word aligner for the 1:7 SDR LVDS receive path.
- Sits directly after the N-channel x X-lane deserialiser, in the pixel_clk domain.
- Rotates each channel's deserialised clock-lane word until it matches the LVDS clock pattern, then applies the same rotation to that channel's X data lanes.
- Adds per-channel lock tracking, loss-of-lock detection and status counters; the previous receive path had no word-boundary alignment.

Parameters:
- N, 3, number of channels.
- X, 4, data lanes per channel.
- CLK_PATTERN, 7'b1100011, expected aligned clock-lane word; bit 6 is first in time.
- LOCK_COUNT, 16, consecutive matches needed to declare lock; legal range 1..255.
- ERR_LIMIT, 4, consecutive mismatches while locked that drop lock; legal range 1..255.

Ports:
- pixel_clk  in  1  sole clock (deserialiser divided clock).
- reset_n  in  1  asynchronous, active-low reset.
- realign  in  1  synchronous single-cycle pulse; forces every channel to restart alignment.
- clk_word_in  in  N*7  deserialised clock-lane word per channel; channel c at [c*7+:7].
- data_in  in  N*X*7  deserialised data; channel c, lane l at [(c*X+l)*7+:7].
- data_out  out  N*X*7  aligned data, same layout as data_in.
- clk_word_out  out  N*7  aligned clock-lane word per channel.
- chan_locked  out  N  per-channel lock flag.
- all_locked  out  1  AND of chan_locked.
- slip_value  out  N*3  current rotation per channel, 0..6.
- lock_loss_cnt  out  N*8  per-channel count of LOCKED->SEARCH transitions; saturates at 255.

Behaviour:
- Reset: reset_n low clears, asynchronously, all outputs, all prev registers, slips, counters and FSMs. All FSMs enter SEARCH with slip 0.
- Pipeline, per lane: prev <= cur each cycle.
  - The window is {prev,cur} (14 bits); the rotated word is window[s+6:s], where s is the channel slip.
  - The rotated word is registered into data_out/clk_word_out.
  - Latency: an input sampled at edge t appears at edge t+1, combined with the word from edge t-1.
- All X data lanes and the clock lane of a channel use one shared slip. Channels are fully independent.
- Compare source: the FSM compares the registered clk_word_out against CLK_PATTERN.
- FSM per channel: SEARCH, HOLD, VERIFY, LOCKED.
  - SEARCH, match: go to VERIFY with match_cnt=1.
  - SEARCH, mismatch: slip <= (slip==6) ? 0 : slip+1, then go to HOLD.
  - HOLD: lasts exactly 2 cycles so the new slip reaches clk_word_out. No compare is made. Exits to SEARCH.
  - VERIFY, match: match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED and clear err_cnt.
  - VERIFY, mismatch: advance slip, go to HOLD.
  - LOCKED, match: clear err_cnt.
  - LOCKED, mismatch: err_cnt++. When err_cnt reaches ERR_LIMIT, go to SEARCH, keep slip, and increment lock_loss_cnt (saturating).
  - With LOCK_COUNT=1, the SEARCH match goes straight to LOCKED.
- chan_locked is high exactly while the FSM is in LOCKED. It is registered and updates on the same edge as the state.
- realign takes priority over every FSM transition. On the next edge every channel enters SEARCH with slip=0, match_cnt=0 and err_cnt=0. lock_loss_cnt is not changed.
- data_out is always driven, including while unlocked. Downstream logic gates on chan_locked.
- Slip wraps 6 -> 0 indefinitely; there is no timeout.
- Lock bound: with a constant correct pattern, lock is reached within 7*3 + LOCK_COUNT + 2 cycles of reset release.
- Counter widths: match_cnt and err_cnt are 8 bits.

Decomposition:
- Shared header lvds_rx_pkg holds:
  - FSM state encodings (2-bit).
  - Default CLK_PATTERN constant.
  - Slip width constant (3).
  - A channel/lane index-offset function.
- Sub-module lvds_7bit_chan_aligner (one channel, X lanes, FSM and counters), instantiated N times by generate.
- The top level holds only the generate loop and the all_locked reduction.

Test Plan:
1. N=3, X=4. Reset, then hold clk_word_in of every channel at 7'b0011110 (correct slip 3).
   - Required: slip_value=3 on all channels.
   - Required: chan_locked=3'b111 and all_locked=1 within 39 cycles.
   - Required: clk_word_out=7'b1100011.
2. Same setup, but drive each channel's data lane l with rotl3(7'h10+l).
   - Required: after lock, data_out lane l = 7'h10+l.
3. Channels use rotations 0, 5 and 6 respectively.
   - Required: slip_value per channel = 0, 5, 6 (wrap path exercised).
   - Required: each channel locks independently.
4. Locked channel 1; inject 3 consecutive bad words (ERR_LIMIT=4).
   - Required: stays locked.
   - Then inject 4 consecutive bad words. Required: chan_locked[1] drops after the 4th, lock_loss_cnt[1]=1, and it relocks to the same slip once good words resume.
5. All channels locked at slip 3; pulse realign for 1 cycle.
   - Required: next cycle, all chan_locked=0 and slip=0.
   - Required: relock at slip 3; lock_loss_cnt unchanged.
6. Assert reset_n low mid-VERIFY, asynchronously between edges.
   - Required: outputs go to 0 immediately, without waiting for a clock edge.
   - Required: after release, locking behaves identically to scenario 1.

Source files
------------

// File: rtl/lvds_rx_pkg.sv
// lvds_rx_pkg: shared FSM encodings, constants and lane indexing for the LVDS word aligner.
package lvds_rx_pkg;
  typedef enum logic [1:0] {SEARCH = 2'd0, HOLD = 2'd1, VERIFY = 2'd2, LOCKED = 2'd3} align_state_e;
  localparam logic [6:0] CLK_PATTERN_DEF = 7'b1100011;
  localparam int SLIP_W = 3;
  function automatic int lane_off(input int c, input int l, input int x);
    return (c * x + l) * 7;
  endfunction
endpackage

// File: rtl/lvds_n_x_7bit_word_aligner_if.sv
// lvds_n_x_7bit_word_aligner_if: deserialised words in, aligned words and lock status out.
interface lvds_n_x_7bit_word_aligner_if #(parameter int N = 3, parameter int X = 4);
  logic             realign;
  logic [N*7-1:0]   clk_word_in;
  logic [N*X*7-1:0] data_in;
  logic [N*X*7-1:0] data_out;
  logic [N*7-1:0]   clk_word_out;
  logic [N-1:0]     chan_locked;
  logic             all_locked;
  logic [N*3-1:0]   slip_value;
  logic [N*8-1:0]   lock_loss_cnt;
  modport master (output realign, clk_word_in, data_in,
                  input data_out, clk_word_out, chan_locked, all_locked, slip_value, lock_loss_cnt);
  modport slave  (input realign, clk_word_in, data_in,
                  output data_out, clk_word_out, chan_locked, all_locked, slip_value, lock_loss_cnt);
endinterface

// File: rtl/lvds_7bit_chan_aligner.sv
// lvds_7bit_chan_aligner: one channel; finds the slip that turns the clock lane into the
// clock pattern and applies it to all data lanes, with lock/loss-of-lock tracking.
module lvds_7bit_chan_aligner
  import lvds_rx_pkg::*;
#(
  parameter int         X           = 4,
  parameter logic [6:0] CLK_PATTERN = CLK_PATTERN_DEF,
  parameter int         LOCK_COUNT  = 16,
  parameter int         ERR_LIMIT   = 4
) (
  input  logic              pixel_clk,
  input  logic              reset_n,
  input  logic              realign,
  input  logic [6:0]        clk_in,
  input  logic [X*7-1:0]    dat_in,
  output logic [6:0]        clk_out,
  output logic [X*7-1:0]    dat_out,
  output logic              locked,
  output logic [SLIP_W-1:0] slip,
  output logic [7:0]        loss_cnt
);
  align_state_e      state_q, state_d;
  logic [6:0]        prev_clk_q, clk_out_q, clk_out_d;
  logic [X*7-1:0]    prev_dat_q, dat_out_q, dat_out_d;
  logic [SLIP_W-1:0] slip_q, slip_d, slip_nx;
  logic [7:0]        mcnt_q, mcnt_d, ecnt_q, ecnt_d, loss_q, loss_d;
  logic              hold_q, hold_d, locked_q, match;
  function automatic logic [6:0] rot(input logic [6:0] p, input logic [6:0] c, input logic [SLIP_W-1:0] s);
    logic [13:0] w;
    w = {p, c} >> s;
    return w[6:0];
  endfunction
  always_comb begin
    dat_out_d = '0;
    clk_out_d = rot(prev_clk_q, clk_in, slip_q);
    for (int l = 0; l < X; l++)
      dat_out_d[lane_off(0, l, X)+:7] = rot(prev_dat_q[lane_off(0, l, X)+:7], dat_in[lane_off(0, l, X)+:7], slip_q);
  end
  assign match   = clk_out_q == CLK_PATTERN;
  assign slip_nx = (slip_q == 3'd6) ? 3'd0 : slip_q + 3'd1;
  always_comb begin
    state_d = state_q;
    slip_d  = slip_q;
    mcnt_d  = mcnt_q;
    ecnt_d  = ecnt_q;
    hold_d  = hold_q;
    loss_d  = loss_q;
    if (realign) begin
      state_d = SEARCH;
      slip_d  = '0;
      mcnt_d  = '0;
      ecnt_d  = '0;
      hold_d  = 1'b0;
    end else begin
      case (state_q)
        SEARCH, VERIFY: begin
          mcnt_d  = (state_q == SEARCH) ? 8'd1 : mcnt_q + 8'd1;
          state_d = !match ? HOLD : (mcnt_d == 8'(LOCK_COUNT)) ? LOCKED : VERIFY;
          ecnt_d  = '0;
          slip_d  = match ? slip_q : slip_nx;
          hold_d  = 1'b0;
        end
        HOLD: begin
          hold_d  = 1'b1;
          state_d = hold_q ? SEARCH : HOLD;
        end
        default: begin
          ecnt_d  = match ? 8'd0 : ecnt_q + 8'd1;
          // Dropping lock keeps the slip: a burst of bad words rarely means the boundary moved.
          if (ecnt_d == 8'(ERR_LIMIT)) begin
            state_d = SEARCH;
            ecnt_d  = '0;
            loss_d  = (&loss_q) ? loss_q : loss_q + 8'd1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SEARCH;
      prev_clk_q <= '0;
      prev_dat_q <= '0;
      clk_out_q  <= '0;
      dat_out_q  <= '0;
      slip_q     <= '0;
      mcnt_q     <= '0;
      ecnt_q     <= '0;
      hold_q     <= 1'b0;
      loss_q     <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_clk_q <= clk_in;
      prev_dat_q <= dat_in;
      clk_out_q  <= clk_out_d;
      dat_out_q  <= dat_out_d;
      slip_q     <= slip_d;
      mcnt_q     <= mcnt_d;
      ecnt_q     <= ecnt_d;
      hold_q     <= hold_d;
      loss_q     <= loss_d;
      locked_q   <= state_d == LOCKED;
    end
  end
  assign clk_out  = clk_out_q;
  assign dat_out  = dat_out_q;
  assign locked   = locked_q;
  assign slip     = slip_q;
  assign loss_cnt = loss_q;
endmodule

// File: rtl/lvds_n_x_7bit_word_aligner.sv
// lvds_n_x_7bit_word_aligner: N independent per-channel word aligners plus the all-locked flag.
module lvds_n_x_7bit_word_aligner
  import lvds_rx_pkg::*;
#(
  parameter int         N           = 3,
  parameter int         X           = 4,
  parameter logic [6:0] CLK_PATTERN = CLK_PATTERN_DEF,
  parameter int         LOCK_COUNT  = 16,
  parameter int         ERR_LIMIT   = 4
) (
  input logic pixel_clk,
  input logic reset_n,
  lvds_n_x_7bit_word_aligner_if.slave bus
);
  genvar c;
  generate
    for (c = 0; c < N; c++) begin : g_ch
      lvds_7bit_chan_aligner #(
        .X(X), .CLK_PATTERN(CLK_PATTERN), .LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT)
      ) u_ch (
        .pixel_clk(pixel_clk),
        .reset_n  (reset_n),
        .realign  (bus.realign),
        .clk_in   (bus.clk_word_in[c*7+:7]),
        .dat_in   (bus.data_in[lane_off(c, 0, X)+:X*7]),
        .clk_out  (bus.clk_word_out[c*7+:7]),
        .dat_out  (bus.data_out[lane_off(c, 0, X)+:X*7]),
        .locked   (bus.chan_locked[c]),
        .slip     (bus.slip_value[c*SLIP_W+:SLIP_W]),
        .loss_cnt (bus.lock_loss_cnt[c*8+:8])
      );
    end
  endgenerate
  assign bus.all_locked = &bus.chan_locked;
endmodule

// File: tb/tb_lvds_n_x_7bit_word_aligner.sv
// tb_lvds_n_x_7bit_word_aligner: directed scenarios checked every cycle against a behavioural model.
module tb_lvds_n_x_7bit_word_aligner;
  localparam int N = 3, X = 4, LC = 16, EL = 4;
  localparam logic [6:0] P = 7'b1100011;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic run_cmp = 1'b0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  lvds_n_x_7bit_word_aligner_if #(.N(N), .X(X)) bus();
  lvds_n_x_7bit_word_aligner dut (.pixel_clk(clk), .reset_n(rst_n), .bus(bus));
  logic [6:0] m_pc[N], m_oc[N];
  logic [6:0] m_pd[N][X], m_od[N][X];
  int m_slip[N], m_streak[N], m_bad[N], m_wait[N], m_loss[N];
  bit m_lock[N];
  int lt[N];
  function automatic logic [6:0] rotl(input logic [6:0] w, input int k);
    logic [13:0] d;
    d = {w, w} << k;
    return d[13:7];
  endfunction
  function automatic logic [6:0] pick(input logic [6:0] p, input logic [6:0] c, input int s);
    logic [13:0] w;
    w = {p, c} >> s;
    return w[6:0];
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask
  // Model: a channel either waits out a slip change, counts good compares towards lock,
  // or (once locked) counts bad compares towards dropping lock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        m_pc[c] <= '0; m_oc[c] <= '0; m_slip[c] <= 0; m_streak[c] <= 0;
        m_bad[c] <= 0; m_wait[c] <= 0; m_loss[c] <= 0; m_lock[c] <= 1'b0;
        for (int l = 0; l < X; l++) begin m_pd[c][l] <= '0; m_od[c][l] <= '0; end
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        if (bus.realign) begin
          m_slip[c] <= 0; m_streak[c] <= 0; m_bad[c] <= 0; m_wait[c] <= 0; m_lock[c] <= 1'b0;
        end else if (m_wait[c] > 0) m_wait[c] <= m_wait[c] - 1;
        else if (m_lock[c]) begin
          if (m_oc[c] == P) m_bad[c] <= 0;
          else if (m_bad[c] + 1 == EL) begin
            m_lock[c] <= 1'b0; m_bad[c] <= 0; m_streak[c] <= 0;
            m_loss[c] <= (m_loss[c] == 255) ? 255 : m_loss[c] + 1;
          end else m_bad[c] <= m_bad[c] + 1;
        end else if (m_oc[c] == P) begin
          m_streak[c] <= m_streak[c] + 1;
          if (m_streak[c] + 1 == LC) begin m_lock[c] <= 1'b1; m_bad[c] <= 0; end
        end else begin
          m_slip[c] <= (m_slip[c] + 1) % 7; m_streak[c] <= 0; m_wait[c] <= 2;
        end
        m_oc[c] <= pick(m_pc[c], bus.clk_word_in[c*7+:7], m_slip[c]);
        m_pc[c] <= bus.clk_word_in[c*7+:7];
        for (int l = 0; l < X; l++) begin
          m_od[c][l] <= pick(m_pd[c][l], bus.data_in[(c*X+l)*7+:7], m_slip[c]);
          m_pd[c][l] <= bus.data_in[(c*X+l)*7+:7];
        end
      end
    end
  end
  always @(negedge clk) begin
    if (run_cmp) begin
      logic all;
      all = 1'b1;
      for (int c = 0; c < N; c++) begin
        chk("m_clk_out", bus.clk_word_out[c*7+:7], m_oc[c]);
        chk("m_locked", bus.chan_locked[c], m_lock[c]);
        chk("m_slip", bus.slip_value[c*3+:3], m_slip[c]);
        chk("m_loss", bus.lock_loss_cnt[c*8+:8], m_loss[c]);
        for (int l = 0; l < X; l++) chk("m_data_out", bus.data_out[(c*X+l)*7+:7], m_od[c][l]);
        all = all & m_lock[c];
      end
      chk("m_all_locked", bus.all_locked, all);
    end
  end
  task automatic set_in(input int r0, input int r1, input int r2);
    int r[3];
    r = '{r0, r1, r2};
    for (int c = 0; c < N; c++) begin
      bus.clk_word_in[c*7+:7] = rotl(P, r[c]);
      for (int l = 0; l < X; l++) bus.data_in[(c*X+l)*7+:7] = rotl(7'h10 + 7'(l), r[c]);
    end
  endtask
  task automatic wait_lock(output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.all_locked === 1'b1) begin n = i; break; end
    end
    if (n == 0) chk("lock_timeout", 0, 1);
  endtask
  task automatic chk_data(input string n);
    for (int c = 0; c < N; c++)
      for (int l = 0; l < X; l++) chk(n, bus.data_out[(c*X+l)*7+:7], 7'h10 + 7'(l));
  endtask
  initial begin
    int n;
    bus.realign = 1'b0;
    set_in(3, 3, 3);
    #1 rst_n = 1'b0;
    #2 run_cmp = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_locked", bus.chan_locked, 0);
    chk("rst_slip", bus.slip_value, 0);
    chk("rst_clk_out", bus.clk_word_out, 0);
    rst_n = 1'b1;
    wait_lock(n);
    chk("t1_lock_cycles", n, 25);
    chk("t1_slip", bus.slip_value, 9'b011_011_011);
    chk("t1_clk_out", bus.clk_word_out, {3{P}});
    chk_data("t2_data_out");
    bus.clk_word_in[13:7] = 7'b0000110;
    repeat (3) @(negedge clk);
    bus.clk_word_in[13:7] = rotl(P, 3);
    repeat (3) @(negedge clk);
    chk("t4_keep_locked", bus.chan_locked, 3'b111);
    chk("t4_loss0", bus.lock_loss_cnt, 0);
    bus.clk_word_in[13:7] = 7'b0000110;
    repeat (4) @(negedge clk);
    bus.clk_word_in[13:7] = rotl(P, 3);
    @(negedge clk);
    chk("t4_dropped", bus.chan_locked, 3'b101);
    chk("t4_loss1", bus.lock_loss_cnt, 24'h000100);
    wait_lock(n);
    chk("t4_relock_cycles", n, 16);
    chk("t4_relock_slip", bus.slip_value, 9'b011_011_011);
    bus.realign = 1'b1;
    @(negedge clk);
    bus.realign = 1'b0;
    chk("t5_unlocked", bus.chan_locked, 0);
    chk("t5_slip0", bus.slip_value, 0);
    wait_lock(n);
    chk("t5_relock_cycles", n, 26);
    chk("t5_slip", bus.slip_value, 9'b011_011_011);
    chk("t5_loss", bus.lock_loss_cnt, 24'h000100);
    rst_n = 1'b0;
    set_in(0, 5, 6);
    @(negedge clk);
    rst_n = 1'b1;
    lt = '{0, 0, 0};
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) if (lt[c] == 0 && bus.chan_locked[c]) lt[c] = i;
      if (lt[0] != 0 && lt[1] != 0 && lt[2] != 0) break;
    end
    chk("t3_lock_ch0", lt[0], 37);
    chk("t3_lock_ch1", lt[1], 31);
    chk("t3_lock_ch2", lt[2], 34);
    chk("t3_slip", bus.slip_value, 9'b110_101_000);
    chk_data("t3_data_out");
    rst_n = 1'b0;
    set_in(3, 3, 3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("t6_verify_unlocked", bus.chan_locked, 0);
    chk("t6_verify_slip", bus.slip_value, 9'b011_011_011);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_slip", bus.slip_value, 0);
    chk("t6_async_clk_out", bus.clk_word_out, 0);
    chk("t6_async_data", bus.data_out[31:0], 0);
    chk("t6_async_locked", {bus.all_locked, bus.chan_locked}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_lock(n);
    chk("t6_lock_cycles", n, 25);
    chk("t6_slip", bus.slip_value, 9'b011_011_011);
    chk("t6_clk_out", bus.clk_word_out, {3{P}});
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
